// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: sequencer state encodings and
// the IO decode region whose status bit 0 is wr_ready.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        TXF_IDLE      = 2'd0,
        TXF_WAIT_BUSY = 2'd1,
        TXF_WAIT_IDLE = 2'd2
    } txf_state_t;

    localparam logic [3:0] UART_TX_IO_REGION = 4'h2;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO. Only the pointers and the occupancy counter are
// reset, so the storage array can map onto LUTRAM/BRAM.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int DEPTH_BITS = $clog2(DEPTH);
    localparam logic [DEPTH_BITS:0] FULL_LEVEL = DEPTH[DEPTH_BITS:0];

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg;
    logic [DEPTH_BITS-1:0] rd_ptr_reg;
    logic [DEPTH_BITS:0]   level_reg;
    logic                  push_ok;
    logic                  pop_ok;

    // Full/empty come from the registered level, so a push into a full FIFO is
    // refused even if a pop happens in the same cycle.
    assign full    = (level_reg == FULL_LEVEL);
    assign empty   = (level_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Head is read asynchronously; the consumer registers it on pop.
    assign head_data = mem[rd_ptr_reg];
    assign level     = level_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the IO decode and the UART transmitter, plus the sequencer
// that hands one byte at a time to the sendData/sendReq/ready handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    input  logic                   tx_ready
);

    localparam int TMR_BITS = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(BUSY_TIMEOUT - 1);

    txf_state_t          state_reg;
    logic [TMR_BITS-1:0] timer_reg;
    logic [7:0]          tx_data_reg;
    logic                tx_send_reg;
    logic                overflow_reg;
    logic [7:0]          fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign fifo_pop = (state_reg == TXF_IDLE) && !fifo_empty && tx_ready;
    assign wr_ready = !fifo_full;
    assign overflow = overflow_reg;
    assign tx_data  = tx_data_reg;
    assign tx_send  = tx_send_reg;

    // A uart that never acknowledges must not stall the queue: after
    // BUSY_TIMEOUT ready-high cycles the byte is treated as sent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= TXF_IDLE;
            timer_reg   <= '0;
            tx_data_reg <= 8'h00;
            tx_send_reg <= 1'b0;
        end else begin
            tx_send_reg <= 1'b0;
            case (state_reg)
                TXF_IDLE: begin
                    if (fifo_pop) begin
                        tx_data_reg <= fifo_head;
                        tx_send_reg <= 1'b1;
                        timer_reg   <= '0;
                        state_reg   <= TXF_WAIT_BUSY;
                    end
                end
                TXF_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_reg <= TXF_WAIT_IDLE;
                    end else if (timer_reg == TMR_LAST) begin
                        state_reg <= TXF_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                TXF_WAIT_IDLE: begin
                    if (tx_ready) begin
                        state_reg <= TXF_IDLE;
                    end
                end
                default: state_reg <= TXF_IDLE;
            endcase
        end
    end

    // A dropped write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_reg <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: behavioural uart model, byte
// scoreboard and a table-driven fill/overflow sequence.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_ready = 1'b1;
    logic       wr_ready;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_send;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_ready (tx_ready)
    );

    typedef enum {M_NORMAL, M_HOLD, M_NEVER} mode_t;

    typedef struct {
        logic [7:0] data;
        int         exp_level;
        int         exp_ready;
        int         exp_ovf;
    } fill_vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_send = -100;
    int         send_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    mode_t      mode = M_NORMAL;
    int         busy_len = 2;
    bit         rand_busy = 1'b0;
    int         busy_cnt = 0;
    fill_vec_t  fill_tab[17];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor followed by the uart model, both on the falling edge.
    always @(negedge clk) begin
        if (tx_send) begin
            send_count++;
            check("send_gap_ge_3", int'((cyc - last_send) >= 3), 1);
            last_send = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_send: got byte 0x%02h expected no send", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                $display("send 0x%02h (expect 0x%02h) at cycle %0d", tx_data, exp_byte, cyc);
                check("tx_byte", int'(tx_data), int'(exp_byte));
            end
        end
        case (mode)
            M_HOLD: begin
                tx_ready = 1'b0;
                busy_cnt = 0;
            end
            M_NEVER: tx_ready = 1'b1;
            default: begin
                if (tx_send) begin
                    tx_ready = 1'b0;
                    busy_cnt = rand_busy ? int'($urandom_range(1, 10)) : busy_len;
                end else if (busy_cnt > 1) begin
                    busy_cnt--;
                end else begin
                    busy_cnt = 0;
                    tx_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d, input bit expect_sent);
        if (expect_sent) exp_q.push_back(d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        $display("write 0x%02h level=%0d wr_ready=%0d overflow=%0d", d, level, wr_ready, overflow);
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && level == 0 && dut.state_reg == TXF_IDLE) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(name, int'(done), 1);
        check({name, "_level"}, int'(level), 0);
    endtask

    task automatic wait_pop_ready(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_ready && dut.state_reg == TXF_IDLE && level != 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(name, int'(done), 1);
    endtask

    task automatic wait_send(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tx_send) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(name, int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        int s0;
        for (int i = 0; i < 17; i++) begin
            fill_tab[i].data      = 8'(i);
            fill_tab[i].exp_level = (i < DEPTH) ? i + 1 : DEPTH;
            fill_tab[i].exp_ready = (i < DEPTH - 1) ? 1 : 0;
            fill_tab[i].exp_ovf   = (i == DEPTH) ? 1 : 0;
        end

        // Reset and idle quiet period
        resetn = 1'b0;
        repeat (5) tick();
        resetn = 1'b1;
        tick();
        check("rst_level", int'(level), 0);
        check("rst_wr_ready", int'(wr_ready), 1);
        check("rst_overflow", int'(overflow), 0);
        check("rst_tx_send", int'(tx_send), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_state", int'(dut.state_reg), int'(TXF_IDLE));
        s0 = send_count;
        repeat (20) tick();
        check("idle_no_pulse", send_count, s0);

        // Single byte latency
        wr_byte(8'h41, 1'b1);
        check("single_send_not_yet", int'(tx_send), 0);
        check("single_level1", int'(level), 1);
        tick();
        check("single_send_pulse", int'(tx_send), 1);
        check("single_tx_data", int'(tx_data), 8'h41);
        tick();
        check("single_pulse_one_cycle", int'(tx_send), 0);
        repeat (10) tick();
        check("single_level0", int'(level), 0);
        check("single_state_idle", int'(dut.state_reg), int'(TXF_IDLE));

        // Fill and overflow with uart held busy
        mode = M_HOLD;
        repeat (2) tick();
        for (int i = 0; i < 17; i++) begin
            wr_byte(fill_tab[i].data, i < DEPTH);
            check("fill_level", int'(level), fill_tab[i].exp_level);
            check("fill_wr_ready", int'(wr_ready), fill_tab[i].exp_ready);
            check("fill_overflow", int'(overflow), fill_tab[i].exp_ovf);
        end
        mode = M_NORMAL;
        wait_drain(400, "fill_drain");
        check("ovf_sticky", int'(overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Push in the same cycle as a pop at level 3
        mode = M_HOLD;
        tick();
        wr_byte(8'h51, 1'b1);
        wr_byte(8'h52, 1'b1);
        wr_byte(8'h53, 1'b1);
        check("pp_level3", int'(level), 3);
        busy_len = 10;
        mode = M_NORMAL;
        wait_pop_ready("pp_pop_ready");
        wr_byte(8'h54, 1'b1);
        check("pp_level_held", int'(level), 3);
        check("pp_send", int'(tx_send), 1);
        wait_drain(300, "pp_drain");

        // Write at level 16 during a pop is dropped
        mode = M_HOLD;
        busy_len = 2;
        tick();
        for (int i = 0; i < DEPTH; i++) wr_byte(8'(8'h60 + i), 1'b1);
        check("fullpop_level16", int'(level), DEPTH);
        mode = M_NORMAL;
        wait_pop_ready("fullpop_pop_ready");
        wr_byte(8'hEE, 1'b0);
        check("fullpop_overflow", int'(overflow), 1);
        check("fullpop_level15", int'(level), DEPTH - 1);
        check("fullpop_send", int'(tx_send), 1);
        wait_drain(400, "fullpop_drain");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Streaming with random busy lengths (pointer wrap)
        rand_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int w = 0; w < 200 && !wr_ready; w++) tick();
            check("wrap_wr_ready", int'(wr_ready), 1);
            wr_byte(8'(i * 7 + 3), 1'b1);
        end
        wait_drain(2000, "wrap_drain");
        check("wrap_no_overflow", int'(overflow), 0);
        rand_busy = 1'b0;

        // Busy timeout: uart never drops ready
        mode = M_NEVER;
        tick();
        wr_byte(8'hA1, 1'b1);
        wr_byte(8'hA2, 1'b1);
        wait_send("to_first_send");
        repeat (BUSY_TIMEOUT) tick();
        check("to_state_idle", int'(dut.state_reg), int'(TXF_IDLE));
        check("to_no_send_yet", int'(tx_send), 0);
        tick();
        check("to_second_send", int'(tx_send), 1);
        check("to_second_data", int'(tx_data), 8'hA2);
        wait_drain(50, "to_drain");

        // Asynchronous reset while in WAIT_IDLE with level 5
        mode = M_HOLD;
        tick();
        for (int i = 0; i < 6; i++) wr_byte(8'(8'hB0 + i), 1'b1);
        busy_len = 50;
        mode = M_NORMAL;
        wait_send("rst_mid_send");
        tick();
        tick();
        check("rst_mid_wait_idle", int'(dut.state_reg), int'(TXF_WAIT_IDLE));
        check("rst_mid_level5", int'(level), 5);
        resetn = 1'b0;
        #1;
        check("rst_mid_level0", int'(level), 0);
        check("rst_mid_wr_ready", int'(wr_ready), 1);
        check("rst_mid_tx_send", int'(tx_send), 0);
        check("rst_mid_tx_data", int'(tx_data), 0);
        check("rst_mid_state", int'(dut.state_reg), int'(TXF_IDLE));
        exp_q.delete();
        repeat (2) tick();
        resetn = 1'b1;
        s0 = send_count;
        repeat (20) tick();
        check("rst_mid_no_send", send_count, s0);
        check("rst_mid_level_after", int'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
